ecc32_err_monitor: RTL

Registered error-accounting stage placed directly downstream of the 32-bit ECC decoder on the ALCT receive path. It takes the decoder's corrected word and 2-bit error code, re-registers them for the rest of the pipeline, and keeps saturating counters of corrected, uncorrectable and check-bit errors for VME readout. It also captures the first error after each clear and can freeze accounting on an uncorrectable error. A holdoff window after reset or clear suppresses counting while the link settles.

---
 rtl/ecc_pkg.sv | 13 +
 rtl/sat_counter.sv | 28 ++
 rtl/ecc32_err_monitor.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ecc_pkg.sv
// Shared constants for the ECC32 error monitor: decoder error codes and FSM state encodings.
package ecc_pkg;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_SGL  = 2'b01;
    localparam logic [1:0] ERR_DBL  = 2'b10;
    localparam logic [1:0] ERR_CHK  = 2'b11;

    localparam logic [1:0] ST_BLANK  = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FROZEN = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// CNT_W-wide up-counter that sticks at all-ones; clear takes priority over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ecc32_err_monitor.sv
// Re-registers the ECC decoder output and keeps saturating error/word counts,
// a first-error capture and a double-error alarm, gated by a post-clear holdoff FSM.
module ecc32_err_monitor
    import ecc_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int HOLDOFF = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             dec_vld,
    input  logic [31:0]      dec_data,
    input  logic [1:0]       dec_err,
    input  logic             cnt_clr,
    input  logic             freeze_on_dbl,
    output logic [31:0]      data_out,
    output logic             data_vld,
    output logic [1:0]       err_out,
    output logic [CNT_W-1:0] sec_cnt,
    output logic [CNT_W-1:0] ded_cnt,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic             first_err_vld,
    output logic [1:0]       first_err_code,
    output logic [CNT_W-1:0] first_err_word,
    output logic             ded_alarm,
    output logic [1:0]       state
);

    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    logic [31:0]      data_q;
    logic             vld_q;
    logic [1:0]       err_q;
    logic [1:0]       state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             fe_vld_q, fe_vld_d;
    logic [1:0]       fe_code_q, fe_code_d;
    logic [CNT_W-1:0] fe_word_q, fe_word_d;
    logic             alarm_q, alarm_d;

    logic clr;
    logic counted;

    // Reset and VME clear share one path into the counters, capture and FSM.
    assign clr     = reset | cnt_clr;
    assign counted = (state_q == ST_RUN) && dec_vld && !clr;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (clr) begin
            state_d = ST_BLANK;
            hold_d  = HW'(HOLDOFF - 1);
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (hold_q == '0) state_d = ST_RUN;
                    else              hold_d  = hold_q - HW'(1);
                end
                ST_RUN: begin
                    if (counted && (dec_err == ERR_DBL) && freeze_on_dbl) state_d = ST_FROZEN;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        fe_vld_d  = fe_vld_q;
        fe_code_d = fe_code_q;
        fe_word_d = fe_word_q;
        alarm_d   = counted && (dec_err == ERR_DBL);
        if (clr) begin
            fe_vld_d  = 1'b0;
            fe_code_d = ERR_NONE;
            fe_word_d = '0;
        end else if (counted && (dec_err != ERR_NONE) && !fe_vld_q) begin
            fe_vld_d  = 1'b1;
            fe_code_d = dec_err;
            fe_word_d = word_cnt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q    <= '0;
            vld_q     <= 1'b0;
            err_q     <= ERR_NONE;
            state_q   <= ST_BLANK;
            hold_q    <= HW'(HOLDOFF - 1);
            fe_vld_q  <= 1'b0;
            fe_code_q <= ERR_NONE;
            fe_word_q <= '0;
            alarm_q   <= 1'b0;
        end else begin
            data_q    <= dec_data;
            vld_q     <= dec_vld;
            err_q     <= dec_err;
            state_q   <= state_d;
            hold_q    <= hold_d;
            fe_vld_q  <= fe_vld_d;
            fe_code_q <= fe_code_d;
            fe_word_q <= fe_word_d;
            alarm_q   <= alarm_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_word_cnt (
        .clock (clock), .clr (clr), .inc (counted), .cnt (word_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_sec_cnt (
        .clock (clock), .clr (clr), .inc (counted && (dec_err == ERR_SGL)), .cnt (sec_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_ded_cnt (
        .clock (clock), .clr (clr), .inc (counted && (dec_err == ERR_DBL)), .cnt (ded_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_chk_cnt (
        .clock (clock), .clr (clr), .inc (counted && (dec_err == ERR_CHK)), .cnt (chk_cnt)
    );

    assign data_out       = data_q;
    assign data_vld       = vld_q;
    assign err_out        = err_q;
    assign first_err_vld  = fe_vld_q;
    assign first_err_code = fe_code_q;
    assign first_err_word = fe_word_q;
    assign ded_alarm      = alarm_q;
    assign state          = state_q;

endmodule
